// File: rtl/ram_arb_pkg.sv
// Shared definitions for the dual-port RAM arbiter: controller states,
// default bus widths and the round-robin selection helper.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int MAX_CLIENTS    = 4;

    // Index of the first set bit of req at or after ptr, wrapping modulo n.
    // Walks offsets from the farthest to the nearest so the nearest wins.
    // Returns ptr when req is empty; callers qualify with |req.
    function automatic int rr_first(input logic [MAX_CLIENTS-1:0] req,
                                    input logic [1:0]             ptr,
                                    input int                     n);
        int j;
        rr_first = int'(ptr);
        for (int off = MAX_CLIENTS - 1; off >= 0; off--) begin
            if (off < n) begin
                j = int'(ptr) + off;
                if (j >= n) j = j - n;
                if (req[2'(j)]) rr_first = j;
            end
        end
    endfunction

endpackage

// File: rtl/ram_arbiter_rr.sv
// Single-channel round-robin arbiter: combinational one-hot grant from the
// request vector, plus the rotating priority pointer.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int N     = 2,
    localparam int CID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [CID_W-1:0] gnt_id
);

    logic [CID_W-1:0]       ptr;
    logic [MAX_CLIENTS-1:0] req_ext;

    // Pick the first requester at or after the pointer; no request, no grant.
    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        gnt_valid      = enable && (|req);
        gnt_id         = CID_W'(rr_first(req_ext, 2'(ptr), N));
        gnt            = '0;
        if (gnt_valid) gnt[gnt_id] = 1'b1;
    end

    // Priority moves just past the winner; idle cycles leave it untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (gnt_valid) begin
            ptr <= (gnt_id == CID_W'(N - 1)) ? '0 : gnt_id + CID_W'(1);
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one dual-port RAM (1 write port, 1 read port, 1-cycle read latency)
// between NUM_CLIENTS requesters. Write and read channels arbitrate
// independently; the block also sequences RAM reset and steers read data
// back to the client that issued the read.
//
// Handshake: a command transfers on a cycle where req_valid[i] & req_ready[i]
// are both high. req_ready is a function of requests and arbiter state only;
// a waiting client must hold its command stable. Read responses are a
// one-cycle rsp_valid strobe with no backpressure.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter  int NUM_CLIENTS = 2,
    localparam int CID_W       = $clog2(NUM_CLIENTS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS-1:0]            req_valid,
    input  logic [NUM_CLIENTS-1:0]            req_wr,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_CLIENTS-1:0]            req_ready,
    output logic [NUM_CLIENTS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic                              ram_rst,
    output logic                              ram_wr_enbl,
    output logic [ADDR_WIDTH-1:0]             ram_wr_addr,
    output logic [DATA_WIDTH-1:0]             ram_wr_data,
    output logic                              ram_rd_enbl,
    output logic [ADDR_WIDTH-1:0]             ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]             ram_rd_data
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       run;

    logic [NUM_CLIENTS-1:0] wr_gnt;
    logic                   wr_gnt_valid;
    logic [CID_W-1:0]       wr_gnt_id;
    logic [NUM_CLIENTS-1:0] rd_gnt;
    logic                   rd_gnt_valid;
    logic [CID_W-1:0]       rd_gnt_id;

    logic                   rd_pend_valid;
    logic [CID_W-1:0]       rd_pend_id;

    // Controller state register; reset pulls straight back to RESET.
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_RESET;
        else      state <= state_nxt;
    end

    // RESET and INIT each last one cycle with the RAM held in reset.
    // Arbitration is also blocked in a cycle where rst is low, so nothing is
    // committed on the edge that performs the reset.
    always_comb begin
        state_nxt = state;
        ram_rst   = 1'b1;
        run       = 1'b0;
        case (state)
            ST_RESET: state_nxt = ST_INIT;
            ST_INIT:  state_nxt = ST_RUN;
            ST_RUN: begin
                ram_rst = 1'b0;
                run     = rst;
            end
            default:  state_nxt = ST_RESET;
        endcase
    end

    rr_arbiter #(.N(NUM_CLIENTS)) u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .enable    (run),
        .req       (req_valid & req_wr),
        .gnt       (wr_gnt),
        .gnt_valid (wr_gnt_valid),
        .gnt_id    (wr_gnt_id)
    );

    rr_arbiter #(.N(NUM_CLIENTS)) u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .enable    (run),
        .req       (req_valid & ~req_wr),
        .gnt       (rd_gnt),
        .gnt_valid (rd_gnt_valid),
        .gnt_id    (rd_gnt_id)
    );

    // Steer the granted clients onto the RAM ports; idle buses read as zero.
    always_comb begin
        req_ready   = wr_gnt | rd_gnt;
        ram_wr_enbl = wr_gnt_valid;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        ram_rd_enbl = rd_gnt_valid;
        ram_rd_addr = '0;
        if (wr_gnt_valid) begin
            ram_wr_addr = req_addr[wr_gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
            ram_wr_data = req_wdata[wr_gnt_id*DATA_WIDTH +: DATA_WIDTH];
        end
        if (rd_gnt_valid) begin
            ram_rd_addr = req_addr[rd_gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Remember who was granted a read so the data can be returned next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_pend_valid <= 1'b0;
            rd_pend_id    <= '0;
        end else begin
            rd_pend_valid <= rd_gnt_valid;
            rd_pend_id    <= rd_gnt_id;
        end
    end

    // Return read data one cycle after the grant. A response due while rst
    // is already low is dropped rather than delivered into a reset.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (rd_pend_valid && rst) begin
            rsp_valid[rd_pend_id] = 1'b1;
            rsp_data              = ram_rd_data;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural read-first dual-port RAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NC = 2;

    logic            clk;
    logic            rst;
    logic [NC-1:0]   req_valid;
    logic [NC-1:0]   req_wr;
    logic [NC*AW-1:0] req_addr;
    logic [NC*DW-1:0] req_wdata;
    logic [NC-1:0]   req_ready;
    logic [NC-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            ram_rst;
    logic            ram_wr_enbl;
    logic [AW-1:0]   ram_wr_addr;
    logic [DW-1:0]   ram_wr_data;
    logic            ram_rd_enbl;
    logic [AW-1:0]   ram_rd_addr;
    logic [DW-1:0]   ram_rd_data;

    int vectors     = 0;
    int miscompares = 0;

    ram_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .NUM_CLIENTS (NC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .ram_rst     (ram_rst),
        .ram_wr_enbl (ram_wr_enbl),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_enbl (ram_rd_enbl),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    // Starts filled with 0xEE so a missing clear is visible, then behaves as
    // a read-first RAM with synchronous clear on ram_rst.
    logic [DW-1:0] mem [256];
    logic          mem_filled = 1'b0;
    logic [DW-1:0] rd_q;

    always @(posedge clk) begin
        if (!mem_filled || ram_rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= mem_filled ? 8'h00 : 8'hEE;
            rd_q       <= 8'h00;
            mem_filled <= 1'b1;
        end else begin
            if (ram_rd_enbl) rd_q <= mem[ram_rd_addr];
            if (ram_wr_enbl) mem[ram_wr_addr] <= ram_wr_data;
        end
    end
    assign ram_rd_data = rd_q;

    // ---------------- driver tasks ----------------
    task automatic idle();
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic drive(input int c, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[c]        = v;
        req_wr[c]           = w;
        req_addr[c*AW +: AW] = a;
        req_wdata[c*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cyc(input string tag, input logic [NC-1:0] rdy,
                             input logic [NC-1:0] rv, input logic [DW-1:0] rd);
        check({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(rv));
        check({tag, ".rsp_data"},  32'(rsp_data),  32'(rd));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0;
        idle();
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);

        // Reset held for three edges with client 0 asking to read 0x10.
        repeat (2) tick();
        settle();
        check("rst.ram_rst", 32'(ram_rst), 32'd1);
        check_cyc("rst", 2'b00, 2'b00, 8'h00);
        check("rst.wr_enbl", 32'(ram_wr_enbl), 32'd0);
        check("rst.rd_enbl", 32'(ram_rd_enbl), 32'd0);
        check("rst.wr_addr", 32'(ram_wr_addr), 32'd0);
        check("rst.wr_data", 32'(ram_wr_data), 32'd0);
        check("rst.rd_addr", 32'(ram_rd_addr), 32'd0);
        tick();
        rst = 1'b1;

        // RESET cycle, then INIT cycle: RAM held in reset, nothing accepted.
        settle();
        check("reset_st.ram_rst", 32'(ram_rst), 32'd1);
        check("reset_st.ready", 32'(req_ready), 32'd0);
        tick();
        settle();
        check("init_st.ram_rst", 32'(ram_rst), 32'd1);
        check("init_st.ready", 32'(req_ready), 32'd0);
        tick();

        // First RUN cycle: client 0 read of 0x10 accepted.
        settle();
        check("run.ram_rst", 32'(ram_rst), 32'd0);
        check_cyc("rd10", 2'b01, 2'b00, 8'h00);
        check("rd10.rd_enbl", 32'(ram_rd_enbl), 32'd1);
        check("rd10.rd_addr", 32'(ram_rd_addr), 32'h10);
        tick();

        // Cleared RAM returns 0x00; client 0 writes 0x5A to 0x20.
        idle();
        drive(0, 1'b1, 1'b1, 8'h20, 8'h5A);
        settle();
        check_cyc("wr20", 2'b01, 2'b01, 8'h00);
        check("wr20.wr_enbl", 32'(ram_wr_enbl), 32'd1);
        check("wr20.wr_addr", 32'(ram_wr_addr), 32'h20);
        check("wr20.wr_data", 32'(ram_wr_data), 32'h5A);
        check("wr20.rd_enbl", 32'(ram_rd_enbl), 32'd0);
        tick();

        // Client 1 reads 0x20 back.
        idle();
        drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
        settle();
        check_cyc("rd20", 2'b10, 2'b00, 8'h00);
        check("rd20.rd_addr", 32'(ram_rd_addr), 32'h20);
        check("rd20.wr_enbl", 32'(ram_wr_enbl), 32'd0);
        tick();

        // Response for client 1; client 1 writes 0x99 to 0x50 (write ptr -> 0).
        idle();
        drive(1, 1'b1, 1'b1, 8'h50, 8'h99);
        settle();
        check_cyc("rsp20", 2'b10, 2'b10, 8'h5A);
        tick();

        // Write contention: both clients write continuously.
        drive(0, 1'b1, 1'b1, 8'h30, 8'h01);
        drive(1, 1'b1, 1'b1, 8'h31, 8'h02);
        settle();
        check_cyc("wc0", 2'b01, 2'b00, 8'h00);
        check("wc0.wr_addr", 32'(ram_wr_addr), 32'h30);
        check("wc0.wr_data", 32'(ram_wr_data), 32'h01);
        tick();
        settle();
        check_cyc("wc1", 2'b10, 2'b00, 8'h00);
        check("wc1.wr_addr", 32'(ram_wr_addr), 32'h31);
        check("wc1.wr_data", 32'(ram_wr_data), 32'h02);
        tick();
        settle();
        check("wc2.ready", 32'(req_ready), 32'(2'b01));
        tick();
        settle();
        check("wc3.ready", 32'(req_ready), 32'(2'b10));
        tick();

        // Seed 0x40 with 0x11 (client 0 write, write ptr -> 1).
        idle();
        drive(0, 1'b1, 1'b1, 8'h40, 8'h11);
        settle();
        check("seed40.ready", 32'(req_ready), 32'(2'b01));
        tick();

        // Same-cycle write 0x77 -> 0x40 by client 0 and read 0x40 by client 1.
        drive(1, 1'b1, 1'b0, 8'h40, 8'h00);
        drive(0, 1'b1, 1'b1, 8'h40, 8'h77);
        settle();
        check_cyc("coll", 2'b11, 2'b00, 8'h00);
        check("coll.wr_enbl", 32'(ram_wr_enbl), 32'd1);
        check("coll.rd_enbl", 32'(ram_rd_enbl), 32'd1);
        tick();

        // Old data comes back; client 1 re-reads.
        idle();
        drive(1, 1'b1, 1'b0, 8'h40, 8'h00);
        settle();
        check_cyc("coll_old", 2'b10, 2'b10, 8'h11);
        tick();
        idle();
        settle();
        check_cyc("coll_new", 2'b00, 2'b10, 8'h77);
        tick();

        // Pointer skip: client 1 alone reads four times, granted every cycle.
        drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
        settle();
        check_cyc("skip0", 2'b10, 2'b00, 8'h00);
        tick();
        drive(1, 1'b1, 1'b0, 8'h30, 8'h00);
        settle();
        check_cyc("skip1", 2'b10, 2'b10, 8'h5A);
        tick();
        drive(1, 1'b1, 1'b0, 8'h31, 8'h00);
        settle();
        check_cyc("skip2", 2'b10, 2'b10, 8'h01);
        tick();
        drive(1, 1'b1, 1'b0, 8'h50, 8'h00);
        settle();
        check_cyc("skip3", 2'b10, 2'b10, 8'h02);
        tick();

        // Both read: client 0 wins first, client 1 follows.
        drive(0, 1'b1, 1'b0, 8'h40, 8'h00);
        drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
        settle();
        check_cyc("both_rd0", 2'b01, 2'b10, 8'h99);
        check("both_rd0.rd_addr", 32'(ram_rd_addr), 32'h40);
        tick();
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        settle();
        check_cyc("both_rd1", 2'b10, 2'b01, 8'h77);
        tick();
        idle();
        settle();
        check_cyc("both_rd2", 2'b00, 2'b10, 8'h5A);
        tick();

        // Mid-operation reset: read granted to client 1, rst drops next cycle.
        drive(1, 1'b1, 1'b0, 8'h40, 8'h00);
        settle();
        check("mid_rd.ready", 32'(req_ready), 32'(2'b10));
        tick();
        rst = 1'b0;
        idle();
        drive(0, 1'b1, 1'b1, 8'h40, 8'h55);
        settle();
        check_cyc("mid_drop", 2'b00, 2'b00, 8'h00);
        check("mid_drop.wr_enbl", 32'(ram_wr_enbl), 32'd0);
        tick();
        rst = 1'b1;
        idle();
        settle();
        check("mid_reset_st.ram_rst", 32'(ram_rst), 32'd1);
        tick();
        settle();
        check("mid_init_st.ram_rst", 32'(ram_rst), 32'd1);
        tick();

        // Back in RUN: write pointer is 0 again, so client 0 wins a tie.
        drive(0, 1'b1, 1'b1, 8'h60, 8'hA0);
        drive(1, 1'b1, 1'b1, 8'h61, 8'hA1);
        settle();
        check_cyc("post_wr0", 2'b01, 2'b00, 8'h00);
        check("post_wr0.wr_addr", 32'(ram_wr_addr), 32'h60);
        tick();
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        settle();
        check("post_wr1.ready", 32'(req_ready), 32'(2'b10));
        tick();

        // 0x40 was cleared by the reset.
        idle();
        drive(0, 1'b1, 1'b0, 8'h40, 8'h00);
        settle();
        check_cyc("post_rd40", 2'b01, 2'b00, 8'h00);
        tick();
        idle();
        settle();
        check_cyc("post_rsp40", 2'b00, 2'b01, 8'h00);
        tick();
        settle();
        check_cyc("quiet", 2'b00, 2'b00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
